// File: rtl/fifo_bus_arbiter.sv
// fifo_bus_arbiter
//    Round-robin arbiter that shares one address-decoded FIFO bus between
//    NUM_REQ requesters. Each requester posts a single push or pop; the
//    arbiter grants one at a time, checks the addressed FIFO's full/empty
//    flag, issues exactly one strobe and returns a one-hot ack with an error
//    flag and, for a successful pop, the popped data.
//
//    Bus polarity follows the FIFO block: bus_read_enable pushes data into
//    the FIFO, bus_write_enable pops its head out to bus_data_out.
//
// Ports
//    clock              rising-edge clock
//    reset              asynchronous active-high reset
//    req                per-requester transaction request
//    req_pop            per-requester op, 0 = push, 1 = pop
//    req_addr           packed per-requester FIFO address
//    req_wdata          packed per-requester push data
//    ack                one-hot, one-cycle completion pulse
//    ack_err            with ack: push to full or pop from empty
//    ack_rdata          with ack: popped data on a successful pop, else 0
//    busy               high whenever the arbiter is not idle
//    bus_active_adress  address driven to the FIFO bank
//    bus_data_in        push data to the FIFO bank
//    bus_read_enable    push strobe
//    bus_write_enable   pop strobe
//    bus_data_out       addressed FIFO's registered output
//    bus_full           full flag of the addressed FIFO
//    bus_empty          empty flag of the addressed FIFO

module fifo_bus_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               req_pop,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               ack,
   output logic                             ack_err,
   output logic [DATA_WIDTH-1:0]            ack_rdata,
   output logic                             busy,
   output logic [ADDR_WIDTH-1:0]            bus_active_adress,
   output logic [DATA_WIDTH-1:0]            bus_data_in,
   output logic                             bus_read_enable,
   output logic                             bus_write_enable,
   input  logic [DATA_WIDTH-1:0]            bus_data_out,
   input  logic                             bus_full,
   input  logic                             bus_empty
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      ISSUE,
      CAPTURE,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       lastGrant_q, lastGrant_d;
   logic                   pop_q, pop_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   err_q, err_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

   logic                   winFound;
   logic [IDX_W-1:0]       winIdx;
   logic [IDX_W-1:0]       cand;
   logic                   pickPop;
   logic [ADDR_WIDTH-1:0]  pickAddr;
   logic [DATA_WIDTH-1:0]  pickWdata;

   // Round-robin search: scan from the requester after the last grant,
   // wrapping, and take the first active request. The fields of the winner
   // are then muxed out with constant slices so no variable part-select
   // is needed.
   always_comb begin
      winFound  = 1'b0;
      winIdx    = '0;
      cand      = '0;
      pickPop   = 1'b0;
      pickAddr  = '0;
      pickWdata = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(lastGrant_q) + k) % NUM_REQ);
         if (!winFound && req[cand]) begin
            winFound = 1'b1;
            winIdx   = cand;
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (winIdx == IDX_W'(k)) begin
            pickPop   = req_pop[k];
            pickAddr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            pickWdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // State and transaction registers. Reset drops any in-flight transaction
   // and points the round-robin pointer at the last requester so the first
   // search after reset starts at requester 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         lastGrant_q <= IDX_W'(NUM_REQ - 1);
         pop_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         pop_q       <= pop_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

   // Next-state logic. Requests are only looked at in IDLE; the flag check
   // happens in SELECT once the address has been on the bus for a cycle.
   // rdata is cleared when a transaction is latched, so pushes and rejected
   // pops complete with zero data.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      pop_d       = pop_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      case (state_q)
         IDLE: begin
            if (winFound) begin
               state_d     = SELECT;
               grant_d     = winIdx;
               lastGrant_d = winIdx;
               pop_d       = pickPop;
               addr_d      = pickAddr;
               wdata_d     = pickWdata;
               err_d       = 1'b0;
               rdata_d     = '0;
            end
         end
         SELECT: begin
            if (pop_q ? bus_empty : bus_full) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = pop_q ? CAPTURE : DONE;
         end
         CAPTURE: begin
            rdata_d = bus_data_out;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode straight from the current state so an asynchronous reset
   // removes the strobes and the ack in the same instant.
   always_comb begin
      busy              = (state_q != IDLE);
      bus_active_adress = '0;
      bus_read_enable   = 1'b0;
      bus_write_enable  = 1'b0;
      bus_data_in       = '0;
      ack               = '0;
      ack_err           = 1'b0;
      ack_rdata         = '0;
      if (state_q == SELECT || state_q == ISSUE || state_q == CAPTURE) begin
         bus_active_adress = addr_q;
      end
      if (state_q == ISSUE) begin
         bus_read_enable  = !pop_q;
         bus_write_enable = pop_q;
         if (!pop_q) begin
            bus_data_in = wdata_q;
         end
      end
      if (state_q == DONE) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            ack[k] = (grant_q == IDX_W'(k));
         end
         ack_err   = err_q;
         ack_rdata = rdata_q;
      end
   end

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// tb_fifo_bus_arbiter
//    Bench for fifo_bus_arbiter. A bank of 16 four-deep FIFOs answers the
//    bus; a transaction-level reference model (queues per FIFO address,
//    round-robin winner by modular search, fixed per-op latencies) predicts
//    every output each cycle.

module tb_fifo_bus_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int ADDR_WIDTH = 4;
   localparam int DATA_WIDTH = 8;
   localparam int FIFO_DEPTH = 4;

   logic                           clock = 1'b0;
   logic                           reset;
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             req_pop;
   logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
   logic [NUM_REQ-1:0]             ack;
   logic                           ack_err;
   logic [DATA_WIDTH-1:0]          ack_rdata;
   logic                           busy;
   logic [ADDR_WIDTH-1:0]          bus_active_adress;
   logic [DATA_WIDTH-1:0]          bus_data_in;
   logic                           bus_read_enable;
   logic                           bus_write_enable;
   logic [DATA_WIDTH-1:0]          bus_data_out = '0;
   logic                           bus_full;
   logic                           bus_empty;

   always #5 clock = ~clock;

   fifo_bus_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clock(clock), .reset(reset),
      .req(req), .req_pop(req_pop), .req_addr(req_addr), .req_wdata(req_wdata),
      .ack(ack), .ack_err(ack_err), .ack_rdata(ack_rdata), .busy(busy),
      .bus_active_adress(bus_active_adress), .bus_data_in(bus_data_in),
      .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
      .bus_data_out(bus_data_out), .bus_full(bus_full), .bus_empty(bus_empty)
   );

   // FIFO bank the arbiter talks to: registered head output, flags decoded
   // from the currently addressed FIFO.
   logic [DATA_WIDTH-1:0] envMem [16][FIFO_DEPTH];
   int                    envCnt [16] = '{default: 0};

   assign bus_full  = (envCnt[bus_active_adress] == FIFO_DEPTH);
   assign bus_empty = (envCnt[bus_active_adress] == 0);

   always @(posedge clock) begin
      if (bus_read_enable && envCnt[bus_active_adress] < FIFO_DEPTH) begin
         envMem[bus_active_adress][envCnt[bus_active_adress]] <= bus_data_in;
         envCnt[bus_active_adress] <= envCnt[bus_active_adress] + 1;
      end else if (bus_write_enable && envCnt[bus_active_adress] > 0) begin
         bus_data_out <= envMem[bus_active_adress][0];
         for (int k = 0; k < FIFO_DEPTH - 1; k++) begin
            envMem[bus_active_adress][k] <= envMem[bus_active_adress][k+1];
         end
         envCnt[bus_active_adress] <= envCnt[bus_active_adress] - 1;
      end
   end

   // Reference model state
   logic [DATA_WIDTH-1:0] modelQ [16][$];
   int                    lastGrantM;
   bit                    inFlight;
   int                    age, ackAge, winM;
   bit                    opM, errM;
   logic [ADDR_WIDTH-1:0] addrM;
   logic [DATA_WIDTH-1:0] dataM, rdataM;

   // Requester side
   bit                    pend  [NUM_REQ];
   bit                    popR  [NUM_REQ];
   logic [ADDR_WIDTH-1:0] addrR [NUM_REQ];
   logic [DATA_WIDTH-1:0] dataR [NUM_REQ];
   logic [NUM_REQ-1:0]    repostMask;
   bit                    randomMode;

   int vectors;
   int miscompares;
   int grantLog[$];
   int rdataLog[$];
   int errLog[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i]                              = pend[i];
         req_pop[i]                          = popR[i];
         req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addrR[i];
         req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = dataR[i];
      end
   endtask

   task automatic postReq(input int i, input bit op, input logic [ADDR_WIDTH-1:0] a,
                          input logic [DATA_WIDTH-1:0] d);
      pend[i]  = 1'b1;
      popR[i]  = op;
      addrR[i] = a;
      dataR[i] = d;
   endtask

   task automatic postRandom(input int i);
      postReq(i, bit'($urandom_range(0, 1)), ADDR_WIDTH'($urandom_range(0, 3)),
              DATA_WIDTH'($urandom));
   endtask

   // Grant the next requester in round-robin order and resolve the
   // transaction against the model FIFO contents.
   task automatic modelPick();
      bit found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int c = (lastGrantM + k) % NUM_REQ;
         if (!found && pend[c]) begin
            found = 1'b1;
            winM  = c;
         end
      end
      lastGrantM = winM;
      opM        = popR[winM];
      addrM      = addrR[winM];
      dataM      = dataR[winM];
      age        = 0;
      inFlight   = 1'b1;
      if (opM) begin
         errM   = (modelQ[addrM].size() == 0);
         rdataM = errM ? '0 : modelQ[addrM].pop_front();
         ackAge = errM ? 2 : 4;
      end else begin
         errM   = (modelQ[addrM].size() >= FIFO_DEPTH);
         rdataM = '0;
         if (!errM) modelQ[addrM].push_back(dataM);
         ackAge = errM ? 2 : 3;
      end
   endtask

   // One clock cycle: check the DUT against the model's view of this cycle,
   // retire an acked transaction, then drive the next request set.
   task automatic stepCycle();
      bit                    wasIdle;
      bit                    anyPend;
      logic                  expBusy, expRd, expWr, expErr;
      logic [ADDR_WIDTH-1:0] expAddr;
      logic [DATA_WIDTH-1:0] expDin, expRdata;
      logic [NUM_REQ-1:0]    expAck;
      @(negedge clock);
      wasIdle  = !inFlight;
      expBusy  = 1'b0;
      expRd    = 1'b0;
      expWr    = 1'b0;
      expErr   = 1'b0;
      expAddr  = '0;
      expDin   = '0;
      expRdata = '0;
      expAck   = '0;
      if (inFlight) begin
         age++;
         expBusy = 1'b1;
         if (age < ackAge) expAddr = addrM;
         if (age == 2 && !errM) begin
            expRd  = !opM;
            expWr  = opM;
            expDin = opM ? '0 : dataM;
         end
         if (age == ackAge) begin
            expAck   = NUM_REQ'(1 << winM);
            expErr   = errM;
            expRdata = rdataM;
         end
      end
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("ack", 32'(ack), 32'(expAck));
      checkOutput("ack_err", 32'(ack_err), 32'(expErr));
      checkOutput("ack_rdata", 32'(ack_rdata), 32'(expRdata));
      checkOutput("bus_addr", 32'(bus_active_adress), 32'(expAddr));
      checkOutput("bus_data_in", 32'(bus_data_in), 32'(expDin));
      checkOutput("read_enable", 32'(bus_read_enable), 32'(expRd));
      checkOutput("write_enable", 32'(bus_write_enable), 32'(expWr));
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ack[i]) begin
            grantLog.push_back(i);
            rdataLog.push_back(int'(ack_rdata));
            errLog.push_back(int'(ack_err));
         end
      end
      if (inFlight && age == ackAge) begin
         inFlight   = 1'b0;
         pend[winM] = 1'b0;
         if (repostMask[winM]) postRandom(winM);
      end
      if (randomMode) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) postRandom(i);
         end
      end
      applyStimulus();
      anyPend = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) anyPend |= pend[i];
      if (wasIdle && anyPend && !reset) modelPick();
   endtask

   task automatic runUntilIdle(input string tag);
      int  guard = 200;
      bit  anyPend;
      do begin
         stepCycle();
         guard--;
         anyPend = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) anyPend |= pend[i];
      end while ((inFlight || anyPend) && guard > 0);
      checkOutput(tag, 32'(inFlight || anyPend), 32'd0);
   endtask

   initial begin
      int exp3 [5] = '{1, 2, 3, 4, 0};
      int exp4 [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      int exp5 [6] = '{0, 1, 2, 3, 0, 1};
      int guard;
      vectors    = 0;
      miscompares = 0;
      lastGrantM = NUM_REQ - 1;
      inFlight   = 1'b0;
      repostMask = '0;
      randomMode = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) postReq(i, 1'b0, '0, '0);
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
      reset = 1'b1;
      applyStimulus();

      // Reset state, then idle with no requests
      stepCycle();
      stepCycle();
      reset = 1'b0;
      repeat (5) stepCycle();

      // Single push
      postReq(0, 1'b0, 4'd7, 8'h11);
      runUntilIdle("push7Drain");

      // Fill an empty FIFO, drain it, then pop once more
      rdataLog.delete();
      errLog.delete();
      for (int v = 1; v <= 4; v++) begin
         postReq(1, 1'b0, 4'd3, 8'(v));
         runUntilIdle("fill3Drain");
      end
      rdataLog.delete();
      errLog.delete();
      for (int v = 0; v < 5; v++) begin
         postReq(2, 1'b1, 4'd3, 8'h00);
         runUntilIdle("pop3Drain");
      end
      checkOutput("pop3Count", 32'(rdataLog.size()), 32'd5);
      for (int i = 0; i < rdataLog.size() && i < 5; i++) begin
         checkOutput("pop3Data", 32'(rdataLog[i]), 32'(exp3[i]));
         checkOutput("pop3Err", 32'(errLog[i]), (i == 4) ? 32'd1 : 32'd0);
      end

      // Push to a full FIFO, then confirm contents are untouched
      for (int v = 1; v <= 5; v++) begin
         errLog.delete();
         postReq(3, 1'b0, 4'd5, 8'(8'hA0 + v));
         runUntilIdle("fill5Drain");
         if (errLog.size() == 1)
            checkOutput("push5Err", 32'(errLog[0]), (v == 5) ? 32'd1 : 32'd0);
         else
            checkOutput("push5AckCount", 32'(errLog.size()), 32'd1);
      end
      rdataLog.delete();
      for (int v = 0; v < 4; v++) begin
         postReq(3, 1'b1, 4'd5, 8'h00);
         runUntilIdle("pop5Drain");
      end
      checkOutput("pop5Count", 32'(rdataLog.size()), 32'd4);
      for (int i = 0; i < rdataLog.size() && i < 4; i++)
         checkOutput("pop5Data", 32'(rdataLog[i]), 32'(exp4[i]));

      // Round-robin order with all requesters held, then a narrower mask
      grantLog.delete();
      repostMask = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) postRandom(i);
      guard = 200;
      while (grantLog.size() < 6 && guard > 0) begin
         stepCycle();
         guard--;
      end
      checkOutput("rrCount", 32'(grantLog.size()), 32'd6);
      for (int i = 0; i < grantLog.size() && i < 6; i++)
         checkOutput("rrOrder", 32'(grantLog[i]), 32'(exp5[i]));
      pend[0]    = 1'b0;
      pend[2]    = 1'b0;
      repostMask = 4'b1010;
      guard = 50;
      while (grantLog.size() < 7 && guard > 0) begin
         stepCycle();
         guard--;
      end
      checkOutput("rrMaskCount", 32'(grantLog.size()), 32'd7);
      if (grantLog.size() >= 7)
         checkOutput("rrMaskGrant", 32'(grantLog[6]), 32'd3);
      repostMask = '0;
      runUntilIdle("rrDrain");

      // Reset while a pop is on the bus
      postReq(2, 1'b0, 4'd9, 8'h5A);
      runUntilIdle("push9Drain");
      postReq(2, 1'b1, 4'd9, 8'h00);
      guard = 20;
      do begin
         stepCycle();
         guard--;
      end while (!(inFlight && age == 2) && guard > 0);
      checkOutput("reachIssue", 32'(inFlight && age == 2), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("rstWriteEn", 32'(bus_write_enable), 32'd0);
      checkOutput("rstReadEn", 32'(bus_read_enable), 32'd0);
      checkOutput("rstAck", 32'(ack), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      if (inFlight && opM && !errM) modelQ[addrM].push_front(rdataM);
      inFlight   = 1'b0;
      lastGrantM = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
      applyStimulus();
      stepCycle();
      stepCycle();
      reset = 1'b0;
      grantLog.delete();
      rdataLog.delete();
      postReq(0, 1'b0, 4'd10, 8'h33);
      postReq(3, 1'b1, 4'd9, 8'h00);
      runUntilIdle("postRstDrain");
      checkOutput("postRstCount", 32'(grantLog.size()), 32'd2);
      if (grantLog.size() == 2) begin
         checkOutput("postRstFirst", 32'(grantLog[0]), 32'd0);
         checkOutput("postRstPop9", 32'(rdataLog[1]), 32'h5A);
      end

      // Randomized traffic
      randomMode = 1'b1;
      repeat (3000) stepCycle();
      randomMode = 1'b0;
      runUntilIdle("randDrain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
